// File: rtl/ioncontrol_count_pkg.sv
// Shared types and constants for the gated edge counter.
// The state enum, default widths and channel-index width helper live here.
package ioncontrol_count_pkg;

    localparam int COUNT_W_DEF = 16;
    localparam int GATE_W_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DRAIN
    } state_t;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gated_edge_counter_edge_detect.sv
// Per-channel edge detector: one prev register plus the edge mask.
// Define GATED_COUNTER_BOTH_EDGES_EN to count falling edges as well.
module edge_detect #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] in,
    output logic [width-1:0] edge_mask
);

    logic [width-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else begin
            prev <= in;
        end
    end

`ifdef GATED_COUNTER_BOTH_EDGES_EN
    assign edge_mask = in ^ prev;
`else
    assign edge_mask = in & ~prev;
`endif

endmodule

// File: rtl/gated_edge_counter.sv
// Gated per-channel edge counter with a one-channel-per-beat result drain.
// Edge polarity is selected by GATED_COUNTER_BOTH_EDGES_EN (see edge_detect).
module gated_edge_counter
    import ioncontrol_count_pkg::*;
#(
    parameter int width   = 8,
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int GATE_W  = GATE_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [width-1:0]           in,
    input  logic                       gate_start,
    input  logic [GATE_W-1:0]          gate_cycles,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COUNT_W-1:0]         out_count,
    output logic [chan_w(width)-1:0]   out_chan,
    output logic                       out_last,
    output logic                       out_sat,
    output logic                       start_err
);

    localparam int CW = chan_w(width);
    localparam logic [COUNT_W-1:0] CMAX = '1;
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    state_t              state;
    logic [GATE_W-1:0]   remaining;
    logic [COUNT_W-1:0]  cnt [width];
    logic [width-1:0]    sat;
    logic [CW-1:0]       idx;
    logic                err;
    logic [width-1:0]    edges;

    edge_detect #(
        .width(width)
    ) u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .edge_mask(edges)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            idx       <= '0;
            sat       <= '0;
            err       <= 1'b0;
            for (int i = 0; i < width; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            err <= gate_start && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (gate_start) begin
                        for (int i = 0; i < width; i++) begin
                            cnt[i] <= '0;
                        end
                        sat <= '0;
                        idx <= '0;
                        if (gate_cycles != '0) begin
                            remaining <= gate_cycles;
                            state     <= ST_COUNT;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_COUNT: begin
                    for (int i = 0; i < width; i++) begin
                        if (edges[i]) begin
                            if (cnt[i] == CMAX) begin
                                sat[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + 1'b1;
                            end
                        end
                    end
                    remaining <= remaining - 1'b1;
                    // remaining==1 marks the final counted cycle
                    if (remaining == GATE_W'(1)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (idx == LAST) begin
                            idx   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DRAIN);
    assign out_chan  = idx;
    assign out_count = out_valid ? cnt[idx] : '0;
    assign out_sat   = out_valid && sat[idx];
    assign out_last  = out_valid && (idx == LAST);
    assign start_err = err;

endmodule
